cpu_trace_capture: RTL and testbench

Synthesizable instruction-boundary trace buffer for the CPUSystem. It snoops a parametrised set of architectural register buses (PC, IR, SP, AR, R1..R4, …) at every fetch-start timing slot. It stores snapshots in a circular buffer around a programmable trigger, then replays them through a request/valid readout port. It replaces per-cycle console dumping with on-chip pre/post-trigger capture usable on hardware.

---
 rtl/cpu_trace_capture_pkg.sv | 20 ++
 rtl/cpu_trace_capture_if.sv | 14 +
 rtl/cpu_trace_capture_ram.sv | 35 +++
 rtl/cpu_trace_capture.sv | 158 +++++++++++++++
 tb/tb_cpu_trace_capture.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_trace_capture_pkg.sv
// Shared types and helpers for the instruction-boundary trace buffer.
//   trace_state_e  : capture FSM states, encoding is visible on the State port
//   T_CAPTURE_BIT  : bit of the CPU timing bus that marks a fetch-start slot
//   clog2_min1     : index width that never collapses to zero bits
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } trace_state_e;

    localparam int T_CAPTURE_BIT = 0;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpu_trace_capture_if.sv
// Readout port of the trace buffer.
//   RdReq   : request one entry (master -> slave)
//   RdData  : oldest stored snapshot, valid with RdValid (slave -> master)
//   RdValid : one-cycle pulse per accepted request (slave -> master)
interface cpu_trace_capture_if #(
    parameter int W = 64
);
    logic         RdReq;
    logic [W-1:0] RdData;
    logic         RdValid;

    modport master (output RdReq, input RdData, input RdValid);
    modport slave  (input RdReq, output RdData, output RdValid);
endinterface

// File: rtl/cpu_trace_capture_ram.sv
// Snapshot storage: DEPTH x WIDTH, synchronous write, registered read.
//   Clock, Reset : clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i         : read request, data appears on rdata_o next edge
//   rdata_o              : registered read data, holds between reads
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int AW    = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge Clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge Clock) begin
        if (Reset)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_capture.sv
// Instruction-boundary trace buffer. Snoops CHANNELS architectural buses on
// every fetch-start slot, keeps a circular window around a programmable
// trigger, then replays the window oldest-first through the readout port.
//   Clock, Reset         : clock, synchronous active-high reset
//   T                    : CPU timing bus, T[T_CAPTURE_BIT] qualifies a sample
//   ChanIn               : packed snooped buses, channel 0 in LSBs
//   Arm                  : start a new capture (honoured in IDLE/DONE)
//   TrigChan/TrigValue   : trigger channel and match value
//   PostCount            : samples after the trigger sample (clamped DEPTH-1)
//   rd                   : readout port (RdReq / RdData / RdValid)
//   Count, Empty         : entries held
//   Triggered, State     : capture status
module cpu_trace_capture
    import cpu_trace_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 16,
    parameter int T_WIDTH    = 8
) (
    input  logic                                Clock,
    input  logic                                Reset,
    input  logic [T_WIDTH-1:0]                  T,
    input  logic [CHANNELS*DATA_WIDTH-1:0]      ChanIn,
    input  logic                                Arm,
    input  logic [clog2_min1(CHANNELS)-1:0]     TrigChan,
    input  logic [DATA_WIDTH-1:0]               TrigValue,
    input  logic [$clog2(DEPTH):0]              PostCount,
    cpu_trace_capture_if.slave                  rd,
    output logic [$clog2(DEPTH):0]              Count,
    output logic                                Empty,
    output logic                                Triggered,
    output logic [1:0]                          State
);

    localparam int W   = CHANNELS * DATA_WIDTH;
    localparam int PW  = clog2_min1(DEPTH);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int TCW = clog2_min1(CHANNELS);

    trace_state_e  state_q, state_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] post_q, post_d;
    logic          trig_q, trig_d;
    logic          rdvalid_q;

    logic          sample;
    logic          hit;
    logic          full;
    logic          rd_accept;
    logic [CW-1:0] post_load;
    logic          unused_t;

    // Only the capture bit of the timing bus matters here.
    assign unused_t = ^T;

    assign sample    = T[T_CAPTURE_BIT] && (state_q == PRE || state_q == POST);
    assign full      = (count_q == CW'(DEPTH));
    // Arm beats a same-cycle read in DONE.
    assign rd_accept = (state_q == DONE) && !Arm && rd.RdReq && (count_q != '0);
    assign post_load = (PostCount > CW'(DEPTH - 1)) ? CW'(DEPTH - 1) : PostCount;

    // Channel mux for the trigger compare; an out-of-range TrigChan never hits.
    always_comb begin
        hit = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (TrigChan == TCW'(c))
                hit = (ChanIn[c*DATA_WIDTH +: DATA_WIDTH] == TrigValue);
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        post_d  = post_q;
        trig_d  = trig_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (Arm) begin
                    state_d = PRE;
                    wptr_d  = '0;
                    rptr_d  = '0;
                    count_d = '0;
                    post_d  = '0;
                    trig_d  = 1'b0;
                end else if (rd_accept) begin
                    rptr_d  = rptr_q + 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
            PRE, POST: begin
                if (sample) begin
                    wptr_d = wptr_q + 1'b1;
                    // A full buffer drops its oldest entry to make room.
                    if (full) rptr_d  = rptr_q + 1'b1;
                    else      count_d = count_q + 1'b1;
                    if (state_q == PRE) begin
                        if (hit) begin
                            trig_d  = 1'b1;
                            post_d  = post_load;
                            state_d = (post_load == '0) ? DONE : POST;
                        end
                    end else begin
                        post_d = post_q - 1'b1;
                        if (post_q == CW'(1)) state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            post_q    <= '0;
            trig_q    <= 1'b0;
            rdvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            post_q    <= post_d;
            trig_q    <= trig_d;
            rdvalid_q <= rd_accept;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (W),
        .AW    (PW)
    ) u_ram (
        .Clock   (Clock),
        .Reset   (Reset),
        .we_i    (sample),
        .waddr_i (wptr_q),
        .wdata_i (ChanIn),
        .re_i    (rd_accept),
        .raddr_i (rptr_q),
        .rdata_o (rd.RdData)
    );

    assign rd.RdValid = rdvalid_q;
    assign Count      = count_q;
    assign Empty      = (count_q == '0);
    assign Triggered  = trig_q;
    assign State      = state_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
module tb_cpu_trace_capture;

    localparam int DW  = 16;
    localparam int CH  = 4;
    localparam int DEP = 8;
    localparam int TW  = 8;
    localparam int W   = CH * DW;
    localparam int CW  = $clog2(DEP) + 1;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [TW-1:0] T;
    logic [W-1:0]  ChanIn;
    logic          Arm;
    logic [1:0]    TrigChan;
    logic [DW-1:0] TrigValue;
    logic [CW-1:0] PostCount;
    logic [CW-1:0] Count;
    logic          Empty;
    logic          Triggered;
    logic [1:0]    State;

    cpu_trace_capture_if #(.W(W)) rdif ();

    cpu_trace_capture #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .DEPTH      (DEP),
        .T_WIDTH    (TW)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .T         (T),
        .ChanIn    (ChanIn),
        .Arm       (Arm),
        .TrigChan  (TrigChan),
        .TrigValue (TrigValue),
        .PostCount (PostCount),
        .rd        (rdif),
        .Count     (Count),
        .Empty     (Empty),
        .Triggered (Triggered),
        .State     (State)
    );

    always #5 Clock = ~Clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the capture window is a queue of snapshots.
    int          m_state;   // 0 IDLE, 1 PRE, 2 POST, 3 DONE
    logic [W-1:0] mq[$];
    bit          m_trig;
    int          m_post;
    bit          m_vld;
    logic [W-1:0] m_rd;

    function automatic logic [W-1:0] mk(input logic [15:0] pc);
        return {~pc, pc ^ 16'h5a5a, pc + 16'h0100, pc};
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst);
        int p;
        if (rst) begin
            m_state = 0; mq.delete(); m_trig = 0; m_post = 0; m_vld = 0; m_rd = '0;
            return;
        end
        m_vld = 0;
        if (m_state == 0 || m_state == 3) begin
            if (Arm) begin
                m_state = 1; mq.delete(); m_trig = 0;
            end else if (m_state == 3 && rdif.RdReq && mq.size() > 0) begin
                m_rd = mq.pop_front(); m_vld = 1;
            end
        end else if (T[0]) begin
            mq.push_back(ChanIn);
            if (mq.size() > DEP) void'(mq.pop_front());
            if (m_state == 1) begin
                if (ChanIn[TrigChan*DW +: DW] == TrigValue) begin
                    m_trig = 1;
                    p = (int'(PostCount) < DEP - 1) ? int'(PostCount) : DEP - 1;
                    m_post = p;
                    m_state = (p == 0) ? 3 : 2;
                end
            end else begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end
    endtask

    task automatic check_all();
        chk("state", W'(State), W'(m_state));
        chk("count", W'(Count), W'(mq.size()));
        chk("empty", W'(Empty), W'(mq.size() == 0));
        chk("triggered", W'(Triggered), W'(m_trig));
        chk("rdvalid", W'(rdif.RdValid), W'(m_vld));
        if (m_vld) chk("rddata", rdif.RdData, m_rd);
    endtask

    task automatic cyc(input bit arm, input bit t0, input bit rdreq, input logic [W-1:0] ch);
        logic [31:0] r;
        r = $urandom();
        Arm = arm;
        T = {r[TW-2:0], t0};
        rdif.RdReq = rdreq;
        ChanIn = ch;
        model_step(1'b0);
        @(posedge Clock); #1;
        check_all();
    endtask

    task automatic do_reset();
        Reset = 1; Arm = 0; rdif.RdReq = 0; T = '0;
        model_step(1'b1);
        @(posedge Clock); #1;
        check_all();
        chk("rddata_reset", rdif.RdData, m_rd);
        Reset = 0;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] v, input logic [CW-1:0] pc);
        TrigChan = ch; TrigValue = v; PostCount = pc;
    endtask

    typedef struct {
        bit          arm, t0, rd;
        logic [15:0] pc;
        int          st, cnt;
        bit          vld;
        logic [15:0] rd0;
    } vec_t;

    vec_t tbl[14];

    initial begin
        Reset = 1; T = '0; ChanIn = '0; Arm = 0; rdif.RdReq = 0;
        cfg(2'd0, 16'd0, '0);

        // Basic capture around PC==6 with two post samples, then drain.
        tbl[0] = '{1, 0, 0, 16'd0, 1, 0, 0, 16'd0};
        for (int i = 0; i < 6; i++)
            tbl[1+i] = '{0, 1, 0, 16'(2*i), (i < 3) ? 1 : (i < 5 ? 2 : 3), i + 1, 0, 16'd0};
        for (int i = 0; i < 6; i++)
            tbl[7+i] = '{0, 0, 1, 16'd0, 3, 5 - i, 1, 16'(2*i)};
        tbl[13] = '{0, 0, 1, 16'd0, 3, 0, 0, 16'd0};

        do_reset();
        cfg(2'd0, 16'h0006, 4'd2);
        foreach (tbl[i]) begin
            cyc(tbl[i].arm, tbl[i].t0, tbl[i].rd, mk(tbl[i].pc));
            chk($sformatf("tbl%0d_state", i), W'(State), W'(tbl[i].st));
            chk($sformatf("tbl%0d_count", i), W'(Count), W'(tbl[i].cnt));
            chk($sformatf("tbl%0d_valid", i), W'(rdif.RdValid), W'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_pc", i), W'(rdif.RdData[15:0]), W'(tbl[i].rd0));
        end

        // Wrap: 12 samples into 8 entries, trigger on the last with no post.
        cfg(2'd0, 16'd22, 4'd0);
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, mk(16'(2*i)));
        chk("wrap_state", W'(State), W'(3));
        chk("wrap_count", W'(Count), W'(8));
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, '0);
            if (i == 0) chk("wrap_first", W'(rdif.RdData[15:0]), W'(8));
            if (i == 7) chk("wrap_last", W'(rdif.RdData[15:0]), W'(22));
        end

        // Clamp: largest encodable PostCount behaves as DEPTH-1.
        cfg(2'd0, 16'd100, 4'd15);
        cyc(1, 0, 0, '0);
        cyc(0, 1, 0, mk(16'd100));
        for (int i = 1; i <= 7; i++) begin
            cyc(0, 1, 0, mk(16'(i)));
            if (i == 6) chk("clamp_still_post", W'(State), W'(2));
        end
        chk("clamp_done", W'(State), W'(3));
        chk("clamp_count", W'(Count), W'(8));
        cyc(0, 0, 1, '0);
        chk("clamp_first", W'(rdif.RdData[15:0]), W'(100));

        // Reset during POST discards everything; a later read is ignored.
        cfg(2'd0, 16'd3, 4'd5);
        cyc(1, 0, 0, '0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 0, mk(16'(i)));
        chk("pre_reset_post", W'(State), W'(2));
        do_reset();
        cyc(0, 0, 1, '0);
        chk("after_reset_valid", W'(rdif.RdValid), W'(0));

        // T[0] low holds the buffer; Arm in PRE ignored; Arm beats RdReq in DONE.
        cfg(2'd0, 16'd50, 4'd0);
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, mk(16'(50)));
        chk("tlow_count", W'(Count), W'(0));
        cyc(1, 0, 0, '0);
        chk("arm_in_pre", W'(State), W'(1));
        cyc(0, 1, 0, mk(16'd50));
        chk("single_done", W'(State), W'(3));
        cyc(1, 0, 1, '0);
        chk("arm_rd_state", W'(State), W'(1));
        chk("arm_rd_valid", W'(rdif.RdValid), W'(0));

        // Randomised traffic against the model; config changes only on arm.
        for (int n = 0; n < 2000; n++) begin
            bit arm, rdq, t0;
            logic [W-1:0] ch;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            arm = (m_state == 3 && mq.size() == 0) ? ($urandom_range(0, 2) == 0)
                                                    : ($urandom_range(0, 19) == 0);
            if (arm && (m_state == 0 || m_state == 3))
                cfg(2'($urandom_range(0, 3)), 16'($urandom_range(0, 15)),
                    CW'($urandom_range(0, 15)));
            rdq = $urandom_range(0, 1) == 1;
            t0  = $urandom_range(0, 1) == 1;
            for (int c = 0; c < CH; c++) ch[c*DW +: DW] = 16'($urandom_range(0, 15));
            cyc(arm, t0, rdq, ch);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
